// File: rtl/instr_fetch.sv
// Instruction fetch stage: credit-limited word fetch over req/gnt/rvalid,
// in-order response FIFO, redirect flush with stale-response drop.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic [6:0]  o_opcode,
  output logic [4:0]  o_rd,
  output logic [2:0]  o_funct3,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [6:0]  o_funct7
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   redir_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [CW-1:0] rsp_dec;
  logic [CW:0]   credit;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic          grant;
  logic          push;
  logic          pop;
  logic          drop;

  assign redir_pc = i_redirect_pc & ~32'h3;
  // In-flight plus buffered words never exceed DEPTH, so a push always fits.
  assign credit = {1'b0, outstanding} + {1'b0, count};

  assign o_imem_req  = !i_rst && !i_redirect && (credit < LIMIT);
  assign o_imem_addr = fetch_pc;

  assign grant   = o_imem_req && i_imem_gnt;
  assign drop    = i_imem_rvalid && (drop_cnt != '0);
  assign push    = i_imem_rvalid && (drop_cnt == '0);
  assign pop     = o_valid && i_ready;
  assign rsp_dec = CW'(i_imem_rvalid);

  assign o_valid = (count != '0);
  assign o_pc    = o_valid ? pc_mem[rd_ptr]  : '0;
  assign o_instr = o_valid ? ins_mem[rd_ptr] : '0;

  assign o_opcode = o_instr[6:0];
  assign o_rd     = o_instr[11:7];
  assign o_funct3 = o_instr[14:12];
  assign o_rs1    = o_instr[19:15];
  assign o_rs2    = o_instr[24:20];
  assign o_funct7 = o_instr[31:25];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (i_redirect) begin
      // Everything still in flight after this cycle's response is stale.
      fetch_pc    <= redir_pc;
      rsp_pc      <= redir_pc;
      outstanding <= outstanding - rsp_dec;
      drop_cnt    <= outstanding - rsp_dec;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (grant)
        fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + CW'(grant) - rsp_dec;
      if (drop)
        drop_cnt <= drop_cnt - CW'(1);
      if (push) begin
        rsp_pc <= rsp_pc + 32'd4;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_redirect && push) begin
      pc_mem[wr_ptr]  <= rsp_pc;
      ins_mem[wr_ptr] <= i_imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model with random grant/latency,
// expected stream derived from sequential-PC and redirect rules.
module tb_instr_fetch;

  localparam int D = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic [6:0]  o_opcode;
  logic [4:0]  o_rd;
  logic [2:0]  o_funct3;
  logic [4:0]  o_rs1;
  logic [4:0]  o_rs2;
  logic [6:0]  o_funct7;

  always #5 i_clk = ~i_clk;

  instr_fetch #(.RESET_PC(RPC), .DEPTH(D)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata(i_imem_rdata),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_pc(o_pc), .o_instr(o_instr),
    .o_opcode(o_opcode), .o_rd(o_rd), .o_funct3(o_funct3),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_funct7(o_funct7)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gnt_mode = 1;
  int lat_lo = 1;
  int lat_hi = 1;
  bit rv_rand = 1'b0;
  bit ovr = 1'b0;
  logic [31:0] ovr_val = '0;
  logic [31:0] pend_a[$];
  int          pend_d[$];
  logic [31:0] exp_pc;

  // Distinct word per address (odd multiplier is a bijection mod 2^32).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr) return ovr_val;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic tick();
    logic g, rv, rq;
    logic [31:0] ad;
    case (gnt_mode)
      0:       g = 1'b0;
      1:       g = 1'b1;
      default: g = 1'($urandom_range(0, 1));
    endcase
    rv = (pend_a.size() > 0) && (pend_d[0] <= cyc);
    if (rv && rv_rand && $urandom_range(0, 3) == 0) rv = 1'b0;
    i_imem_gnt = g;
    i_imem_rvalid = rv;
    i_imem_rdata = rv ? mem_word(pend_a[0]) : $urandom;
    rq = o_imem_req;
    ad = o_imem_addr;
    @(posedge i_clk);
    if (i_rst) begin
      pend_a.delete();
      pend_d.delete();
    end else begin
      if (rv) begin
        void'(pend_a.pop_front());
        void'(pend_d.pop_front());
      end
      if (rq && g) begin
        pend_a.push_back(ad);
        pend_d.push_back(cyc + int'($urandom_range(lat_lo, lat_hi)));
      end
    end
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_ready = 1'b0;
    i_redirect = 1'b1;
    i_redirect_pc = 32'h500;
    gnt_mode = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k > 0) begin
        checks++;
        if (o_imem_req !== 1'b0 || o_valid !== 1'b0) begin
          errors++;
          $display("FAIL reset_ctl: req=%b valid=%b want 0/0", o_imem_req, o_valid);
        end
        checks++;
        if (o_pc !== 32'h0 || o_instr !== 32'h0 || o_opcode !== 7'h0
            || o_rd !== 5'h0 || o_funct7 !== 7'h0 || o_imem_addr !== RPC) begin
          errors++;
          $display("FAIL reset_data: pc=%h instr=%h addr=%h want 0/0/%h",
                   o_pc, o_instr, o_imem_addr, RPC);
        end
      end
      tick();
    end
    i_rst = 1'b0;
    i_redirect = 1'b0;
  endtask

  task automatic test_stream();
    gnt_mode = 1; lat_lo = 1; lat_hi = 1; rv_rand = 1'b0;
    i_ready = 1'b1;
    exp_pc = RPC;
    for (int k = 0; k < 24; k++) begin
      #1;
      if (k == 0) begin
        checks++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== RPC) begin
          errors++;
          $display("FAIL first_req: req=%b addr=%h want 1/%h", o_imem_req, o_imem_addr, RPC);
        end
      end
      if (k < 2) begin
        checks++;
        if (o_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_latency k=%0d: valid=%b want 0", k, o_valid);
        end
      end else begin
        checks++;
        if (o_valid !== 1'b1 || o_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL stream k=%0d: valid=%b pc=%h instr=%h want 1/%h/%h",
                   k, o_valid, o_pc, o_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int acc;
    i_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (o_valid !== 1'b1 || o_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL stall_head k=%0d: valid=%b pc=%h instr=%h want 1/%h/%h",
                 k, o_valid, o_pc, o_instr, exp_pc, mem_word(exp_pc));
      end
      if (k >= 5) begin
        checks++;
        if (o_imem_req !== 1'b0) begin
          errors++;
          $display("FAIL stall_credit k=%0d: req=%b want 0", k, o_imem_req);
        end
      end
      tick();
    end
    i_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (o_valid) begin
        checks++;
        if (o_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL resume: pc=%h instr=%h want %h/%h",
                   o_pc, o_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
        acc++;
      end
      tick();
    end
    checks++;
    if (acc < 15) begin
      errors++;
      $display("FAIL resume_rate: accepted=%0d want >=15", acc);
    end
  endtask

  task automatic test_gnt_stall();
    logic [31:0] a0;
    i_ready = 1'b1;
    gnt_mode = 0;
    #1;
    a0 = o_imem_addr;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (o_imem_req !== 1'b1 || o_imem_addr !== a0) begin
        errors++;
        $display("FAIL gnt_hold k=%0d: req=%b addr=%h want 1/%h", k, o_imem_req, o_imem_addr, a0);
      end
      if (o_valid) begin
        checks++;
        if (o_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL gnt_drain: pc=%h instr=%h want %h", o_pc, o_instr, exp_pc);
        end
        exp_pc += 32'd4;
      end
      tick();
    end
    gnt_mode = 1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (k == 1) begin
        checks++;
        if (o_imem_addr !== a0 + 32'd4) begin
          errors++;
          $display("FAIL gnt_advance: addr=%h want %h", o_imem_addr, a0 + 32'd4);
        end
      end
      if (o_valid) begin
        checks++;
        if (o_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL gnt_resume: pc=%h instr=%h want %h", o_pc, o_instr, exp_pc);
        end
        exp_pc += 32'd4;
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    bit found;
    bit got;
    gnt_mode = 1; lat_lo = 3; lat_hi = 3; i_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      #1;
      if (pend_a.size() >= 2) begin
        found = 1'b1;
      end else begin
        if (o_valid) begin
          checks++;
          if (o_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin
            errors++;
            $display("FAIL redir_pre: pc=%h want %h", o_pc, exp_pc);
          end
          exp_pc += 32'd4;
        end
        tick();
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redir_setup: outstanding=%0d want >=2", pend_a.size());
    end
    i_redirect = 1'b1;
    i_redirect_pc = 32'h103;
    #1;
    checks++;
    if (o_imem_req !== 1'b0) begin
      errors++;
      $display("FAIL redir_noreq: req=%b want 0", o_imem_req);
    end
    tick();
    i_redirect = 1'b0;
    exp_pc = 32'h100;
    #1;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush: valid=%b want 0", o_valid);
    end
    got = 1'b0;
    for (int k = 0; k < 25; k++) begin
      #1;
      if (o_valid) begin
        checks++;
        if (o_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL redir_stream: pc=%h instr=%h want %h/%h",
                   o_pc, o_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
        got = 1'b1;
      end
      tick();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL redir_timeout: valid=0 want 1");
    end
  endtask

  task automatic test_redirect_rvalid();
    bit found;
    bit got;
    gnt_mode = 1; lat_lo = 1; lat_hi = 1; i_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      #1;
      if (k > 6 && o_valid && pend_a.size() > 0 && pend_d[0] <= cyc) begin
        found = 1'b1;
      end else begin
        if (o_valid) begin
          checks++;
          if (o_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin
            errors++;
            $display("FAIL rr_pre: pc=%h want %h", o_pc, exp_pc);
          end
          exp_pc += 32'd4;
        end
        tick();
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rr_setup: no rvalid+valid cycle found want 1");
    end
    i_redirect = 1'b1;
    i_redirect_pc = 32'h200;
    #1;
    tick();
    i_redirect = 1'b0;
    exp_pc = 32'h200;
    #1;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_flush: valid=%b want 0", o_valid);
    end
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (o_valid) begin
        checks++;
        if (o_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL rr_stream: pc=%h instr=%h want %h/%h",
                   o_pc, o_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
        got = 1'b1;
      end
      tick();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rr_timeout: valid=0 want 1");
    end
  endtask

  task automatic test_random();
    bit redir;
    bit prev_redir;
    int acc;
    logic [31:0] w;
    gnt_mode = 2; lat_lo = 1; lat_hi = 3; rv_rand = 1'b1;
    prev_redir = 1'b0;
    acc = 0;
    for (int k = 0; k < 3000; k++) begin
      i_ready = 1'($urandom_range(0, 1));
      redir = ($urandom_range(0, 39) == 0);
      i_redirect = redir;
      i_redirect_pc = $urandom;
      #1;
      if (prev_redir) begin
        checks++;
        if (o_valid !== 1'b0) begin
          errors++;
          $display("FAIL rnd_flush k=%0d: valid=%b want 0", k, o_valid);
        end
      end
      if (redir) begin
        checks++;
        if (o_imem_req !== 1'b0) begin
          errors++;
          $display("FAIL rnd_noreq k=%0d: req=%b want 0", k, o_imem_req);
        end
      end else if (o_valid && i_ready) begin
        w = mem_word(exp_pc);
        checks++;
        if (o_pc !== exp_pc || o_instr !== w || o_opcode !== w[6:0]
            || o_rd !== w[11:7] || o_funct3 !== w[14:12] || o_rs1 !== w[19:15]
            || o_rs2 !== w[24:20] || o_funct7 !== w[31:25]) begin
          errors++;
          $display("FAIL rnd_stream k=%0d: pc=%h instr=%h want %h/%h",
                   k, o_pc, o_instr, exp_pc, w);
        end
        exp_pc += 32'd4;
        acc++;
      end
      tick();
      if (redir) exp_pc = {i_redirect_pc[31:2], 2'b00};
      prev_redir = redir;
    end
    i_redirect = 1'b0;
    checks++;
    if (acc < 200) begin
      errors++;
      $display("FAIL rnd_progress: accepted=%0d want >=200", acc);
    end
  endtask

  task automatic test_fields();
    int acc;
    gnt_mode = 1; lat_lo = 1; lat_hi = 1; rv_rand = 1'b0;
    i_ready = 1'b1;
    ovr = 1'b1;
    ovr_val = 32'h00A2_8293;
    i_redirect = 1'b1;
    i_redirect_pc = 32'hFFFF_FFFE;
    #1;
    tick();
    i_redirect = 1'b0;
    exp_pc = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'hFFFF_FFFC || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_start: req=%b addr=%h valid=%b want 1/fffffffc/0",
               o_imem_req, o_imem_addr, o_valid);
    end
    tick();
    #1;
    checks++;
    if (o_imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr: addr=%h want 00000000", o_imem_addr);
    end
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (o_valid) begin
        checks++;
        if (o_pc !== exp_pc || o_opcode !== 7'b0010011 || o_rd !== 5'd5
            || o_funct3 !== 3'd0 || o_rs1 !== 5'd5 || o_rs2 !== 5'd10
            || o_funct7 !== 7'd0) begin
          errors++;
          $display("FAIL fields: pc=%h op=%b rd=%0d f3=%0d rs1=%0d rs2=%0d f7=%0d want %h/0010011/5/0/5/10/0",
                   o_pc, o_opcode, o_rd, o_funct3, o_rs1, o_rs2, o_funct7, exp_pc);
        end
        exp_pc += 32'd4;
        acc++;
      end
      tick();
    end
    checks++;
    if (acc < 2) begin
      errors++;
      $display("FAIL wrap_progress: accepted=%0d want >=2", acc);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_gnt_stall();
    test_redirect();
    test_redirect_rvalid();
    test_random();
    test_fields();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
